// File: rtl/mem_responder_if.sv
// Request/response bus between a requester and mem_responder.
// Requester is the master; the memory block is the slave.
interface mem_responder_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_ready;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding word memory with a fixed accept-to-response latency.
// Misaligned or out-of-range accesses return an error and never touch memory.
module mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;
    logic        accept;
    logic        access;

    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic          addr_err;
    logic [AW-1:0] idx;
    logic          mem_we;

    logic [31:0] mem [DEPTH];

    assign addr_err = (addr_q[1:0] != 2'b00) | (|addr_q[31:AW+2]);
    assign idx      = addr_q[AW+1:2];
    assign mem_we   = access & we_q & ~addr_err;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        access   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept   = 1'b1;
                    cnt_nx   = CNT_LOAD;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    access   = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            // Response registers are loaded on entry to RESP and cleared on exit.
            if (access) begin
                err_q   <= addr_err;
                rdata_q <= (we_q | addr_err) ? 32'd0 : mem[idx];
            end else if (state == RESP && bus.rsp_ready) begin
                err_q   <= 1'b0;
                rdata_q <= 32'd0;
            end
        end
    end

    // A reset on the access edge discards the pending write.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table, corner sequences,
// random traffic against a word-array model, and latency/spacing at LATENCY 1 and 15.
module tb_mem_responder;
    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if bus0();
    mem_responder_if bus1();
    mem_responder_if bus15();

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );
    mem_responder #(.DEPTH(DEPTH), .LATENCY(15)) dut15 (
        .clk(clk), .rst_n(rst_n), .bus(bus15)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mdl [DEPTH];
    bit          known [DEPTH];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t tbl [16];

    int cyc = 0;
    bit mon_en = 1'b0;
    bit prev1 = 1'b0;
    bit prev15 = 1'b0;
    int acc1[$];
    int rsp1[$];
    int acc15[$];
    int rsp15[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus1.req_valid && bus1.req_ready) acc1.push_back(cyc + 1);
            if (bus1.rsp_valid && !prev1) rsp1.push_back(cyc);
            if (bus15.req_valid && bus15.req_ready) acc15.push_back(cyc + 1);
            if (bus15.rsp_valid && !prev15) rsp15.push_back(cyc);
        end
        prev1  <= bus1.rsp_valid;
        prev15 <= bus15.rsp_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
    endfunction

    task automatic model_update(input logic we, input logic [31:0] a, input logic [31:0] d);
        if (we && !addr_bad(a)) begin
            mdl[a / 4]   = d;
            known[a / 4] = 1'b1;
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge following accept.
    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d);
        int t;
        bus0.req_we    = we;
        bus0.req_addr  = a;
        bus0.req_wdata = d;
        bus0.req_valid = 1'b1;
        t = 0;
        while (!bus0.req_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!bus0.req_ready) check("accept_timeout", 32'(bus0.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus0.req_valid = 1'b0;
        bus0.req_we    = 1'($urandom);
        bus0.req_addr  = $urandom;
        bus0.req_wdata = $urandom;
        check("ready_low_after_accept", 32'(bus0.req_ready), 32'd0);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (!bus0.rsp_valid) begin
                check("wait_rdata_zero", bus0.rsp_rdata, 32'd0);
                check("wait_err_zero", 32'(bus0.rsp_err), 32'd0);
            end
        end while (!bus0.rsp_valid && lat < 40);
        if (!bus0.rsp_valid) check("rsp_timeout", 32'(bus0.rsp_valid), 32'd1);
    endtask

    task automatic finish_rsp(input logic exp_err, input logic [31:0] exp_rd,
                              input bit chk_rd, input int hold);
        check("rsp_err", 32'(bus0.rsp_err), 32'(exp_err));
        if (chk_rd) check("rsp_rdata", bus0.rsp_rdata, exp_rd);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
            check("hold_req_ready", 32'(bus0.req_ready), 32'd0);
            check("hold_rsp_err", 32'(bus0.rsp_err), 32'(exp_err));
            if (chk_rd) check("hold_rsp_rdata", bus0.rsp_rdata, exp_rd);
        end
        bus0.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus0.rsp_ready = 1'b0;
        check("idle_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        check("idle_rdata_zero", bus0.rsp_rdata, 32'd0);
        check("idle_err_zero", 32'(bus0.rsp_err), 32'd0);
        check("idle_req_ready", 32'(bus0.req_ready), 32'd1);
    endtask

    task automatic do_txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input int hold, input logic exp_err,
                          input logic [31:0] exp_rd, input bit chk_rd);
        int lat;
        issue(we, a, d);
        wait_rsp(lat);
        check("latency", 32'(lat), 32'(LAT));
        finish_rsp(exp_err, exp_rd, chk_rd, hold);
        model_update(we, a, d);
    endtask

    task automatic model_txn(input logic we, input logic [31:0] a,
                             input logic [31:0] d, input int hold);
        logic        e;
        logic [31:0] r;
        bit          c;
        e = addr_bad(a);
        r = (we || e) ? 32'd0 : mdl[a / 4];
        c = we || e || known[a / 4];
        do_txn(we, a, d, hold, e, r, c);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        bus0.req_valid = 0; bus0.req_we = 0; bus0.req_addr = 0;
        bus0.req_wdata = 0; bus0.rsp_ready = 0;
        bus1.req_valid = 0; bus1.req_we = 0; bus1.req_addr = 0;
        bus1.req_wdata = 0; bus1.rsp_ready = 0;
        bus15.req_valid = 0; bus15.req_we = 0; bus15.req_addr = 0;
        bus15.req_wdata = 0; bus15.rsp_ready = 0;

        tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 32'h0000_0020, 32'hAAAA_AAAA, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'h0};
        tbl[4]  = '{1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0};
        tbl[5]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[6]  = '{1'b1, 32'h0000_0102, 32'h0000_0001, 1'b1, 32'h0};
        tbl[7]  = '{1'b1, 32'h0000_00FC, 32'h55AA_55AA, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'h55AA_55AA};
        tbl[9]  = '{1'b1, 32'h0000_0011, 32'hFFFF_FFFF, 1'b1, 32'h0};
        tbl[10] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[11] = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 32'h0};
        tbl[12] = '{1'b1, 32'h0000_0100, 32'h1357_9BDF, 1'b1, 32'h0};
        tbl[13] = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hCAFE_F00D};
        tbl[14] = '{1'b0, 32'h8000_0020, 32'h0,         1'b1, 32'h0};
        tbl[15] = '{1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'hAAAA_AAAA};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_req_ready", 32'(bus0.req_ready), 32'd1);
        check("reset_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        check("reset_rsp_rdata", bus0.rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(bus0.rsp_err), 32'd0);

        foreach (tbl[i])
            do_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, i % 3,
                   tbl[i].exp_err, tbl[i].exp_rdata, 1'b1);

        // Response held for 5 cycles while a new write waits behind it.
        issue(1'b0, 32'h10, 32'h0);
        wait_rsp(lat);
        check("hold_seq_latency", 32'(lat), 32'(LAT));
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b1;
        bus0.req_addr  = 32'h10;
        bus0.req_wdata = 32'h0BAD_F00D;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            check("hold5_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
            check("hold5_req_ready", 32'(bus0.req_ready), 32'd0);
            check("hold5_rdata", bus0.rsp_rdata, 32'hDEAD_BEEF);
        end
        bus0.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus0.rsp_ready = 1'b0;
        check("release_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        check("release_req_ready", 32'(bus0.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus0.req_valid = 1'b0;
        check("pending_accepted", 32'(bus0.req_ready), 32'd0);
        wait_rsp(lat);
        check("pending_latency", 32'(lat), 32'(LAT));
        finish_rsp(1'b0, 32'h0, 1'b1, 0);
        model_update(1'b1, 32'h10, 32'h0BAD_F00D);
        do_txn(1'b0, 32'h10, 32'h0, 0, 1'b0, 32'h0BAD_F00D, 1'b1);

        // Reset one cycle after accepting a write discards it.
        issue(1'b1, 32'h20, 32'h1234_5678);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_wait_req_ready", 32'(bus0.req_ready), 32'd1);
        check("rst_wait_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        check("rst_wait_rdata", bus0.rsp_rdata, 32'd0);
        check("rst_wait_err", 32'(bus0.rsp_err), 32'd0);
        do_txn(1'b0, 32'h20, 32'h0, 0, 1'b0, 32'hAAAA_AAAA, 1'b1);

        // Reset during RESP drops the response.
        issue(1'b0, 32'h10, 32'h0);
        wait_rsp(lat);
        check("rst_resp_rdata_before", bus0.rsp_rdata, 32'h0BAD_F00D);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_resp_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        check("rst_resp_rdata", bus0.rsp_rdata, 32'd0);
        check("rst_resp_req_ready", 32'(bus0.req_ready), 32'd1);

        // Request presented during reset is not accepted.
        do_txn(1'b1, 32'h30, 32'h1111_2222, 0, 1'b0, 32'h0, 1'b1);
        rst_n = 1'b0;
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b1;
        bus0.req_addr  = 32'h30;
        bus0.req_wdata = 32'h0000_0077;
        @(posedge clk);
        @(negedge clk);
        bus0.req_valid = 1'b0;
        rst_n = 1'b1;
        check("rst_req_not_accepted", 32'(bus0.req_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("rst_req_no_rsp", 32'(bus0.rsp_valid), 32'd0);
        do_txn(1'b0, 32'h30, 32'h0, 0, 1'b0, 32'h1111_2222, 1'b1);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            int unsigned sel;
            sel = $urandom_range(0, 9);
            if (sel <= 5)      a = 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (sel == 6) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else if (sel == 7) a = 32'(DEPTH * 4 + $urandom_range(0, 1000) * 4);
            else if (sel == 8) a = $urandom;
            else               a = 32'(DEPTH * 4 - 4);
            model_txn(1'($urandom), a, $urandom, int'($urandom_range(0, 3)));
        end

        // Back-to-back reads on the LATENCY=1 and LATENCY=15 instances.
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        bus1.req_valid  = 1'b1;
        bus1.rsp_ready  = 1'b1;
        bus15.req_valid = 1'b1;
        bus15.rsp_ready = 1'b1;
        repeat (90) @(posedge clk);
        #1;
        mon_en = 1'b0;
        bus1.req_valid  = 1'b0;
        bus15.req_valid = 1'b0;

        check("l1_enough_rsp", 32'(rsp1.size() >= 4), 32'd1);
        check("l15_enough_rsp", 32'(rsp15.size() >= 4), 32'd1);
        for (int i = 0; i < rsp1.size() && i < 4; i++) begin
            check("l1_latency", 32'(rsp1[i] - acc1[i]), 32'd1);
            if (i + 1 < acc1.size())
                check("l1_spacing", 32'(acc1[i + 1] - acc1[i]), 32'd3);
        end
        for (int i = 0; i < rsp15.size() && i < 4; i++) begin
            check("l15_latency", 32'(rsp15[i] - acc15[i]), 32'd15);
            if (i + 1 < acc15.size())
                check("l15_spacing", 32'(acc15[i + 1] - acc15[i]), 32'd17);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
